// File: rtl/motor_cmd_pkg.sv
// Shared types for the motor command path: direction encoding used by the
// scheduler, the per-direction generators and the serial-line mux.
package motor_cmd_pkg;

  typedef enum logic [2:0] {
    STOP     = 3'd0,
    FORWARD  = 3'd1,
    BACKWARD = 3'd2,
    LEFT     = 3'd3,
    RIGHT    = 3'd4
  } motor_dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_SENDING,
    ST_GAP
  } sched_state_t;

  localparam int NUM_GEN = 5;

  // Encodings above RIGHT have no generator behind them; they fall back to STOP.
  function automatic motor_dir_t sanitize_dir(input logic [2:0] raw);
    return (raw > 3'd4) ? STOP : motor_dir_t'(raw);
  endfunction

endpackage

// File: rtl/interval_timer.sv
// Loadable down-counter that saturates at zero; expired is high while the
// count sits at zero.
module interval_timer #(
  parameter  int MAX_COUNT = 1,
  localparam int W         = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/motor_cmd_scheduler.sv
// Serialises motor commands onto one shared line: one pending slot, a launch
// cycle to settle the mux, transmission with timeout, then an enforced gap.
module motor_cmd_scheduler
  import motor_cmd_pkg::*;
#(
  parameter int GAP_CLKS     = 50_000,
  parameter int REFRESH_CLKS = 25_000_000,
  parameter int TIMEOUT_CLKS = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] dir_req,
  input  logic [2:0] speed_req,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] gen_done,
  output logic [4:0] gen_rst,
  output logic [2:0] tx_sel,
  output logic [2:0] speed_out,
  output logic       busy,
  output logic       timeout_err
);

  localparam int GAP_W = $clog2(GAP_CLKS + 1);
  localparam int REF_W = $clog2(REFRESH_CLKS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CLKS - 1);
  localparam logic [REF_W-1:0] REF_LOAD = REF_W'(REFRESH_CLKS - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CLKS - 1);

  sched_state_t state, state_nxt;
  motor_dir_t   current_dir, pend_dir;
  logic [2:0]   current_speed, pend_speed;
  logic         pend_vld;
  logic         first_send;
  logic         launch_new;
  logic         tmo_hit;
  logic         done_sel;
  logic         gap_exp, ref_exp, tmo_exp;
  logic         accept;

  assign accept    = req_valid && !pend_vld;
  assign req_ready = !pend_vld;
  assign busy      = (state != ST_IDLE);
  assign done_sel  = gen_done[current_dir];

  interval_timer #(.MAX_COUNT(GAP_CLKS)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state != ST_GAP),
    .en       (state == ST_GAP),
    .load_val (GAP_LOAD),
    .expired  (gap_exp)
  );

  // Counts down from REFRESH_CLKS-1, which mirrors an up-count saturating there.
  interval_timer #(.MAX_COUNT(REFRESH_CLKS)) u_refresh_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state_nxt == ST_LAUNCH),
    .en       ((state == ST_IDLE) || (state == ST_GAP)),
    .load_val (REF_LOAD),
    .expired  (ref_exp)
  );

  interval_timer #(.MAX_COUNT(TIMEOUT_CLKS)) u_timeout_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state != ST_SENDING),
    .en       (state == ST_SENDING),
    .load_val (TMO_LOAD),
    .expired  (tmo_exp)
  );

  always_comb begin
    state_nxt  = state;
    launch_new = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend_vld) begin
          state_nxt  = ST_LAUNCH;
          launch_new = 1'b1;
        end else if (ref_exp && (current_dir != STOP)) begin
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_nxt = ST_SENDING;
      ST_SENDING: begin
        // The generator's done flag may still be stale in the first cycle.
        if (!first_send && done_sel) begin
          state_nxt = ST_GAP;
        end else if (tmo_exp) begin
          state_nxt = ST_GAP;
          tmo_hit   = 1'b1;
        end
      end
      ST_GAP: if (gap_exp) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign timeout_err = tmo_hit;

  always_comb begin
    gen_rst = 5'b11111;
    if (state == ST_SENDING) gen_rst[current_dir] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      current_dir   <= STOP;
      current_speed <= 3'd0;
      tx_sel        <= 3'd0;
      speed_out     <= 3'd0;
      pend_vld      <= 1'b0;
      first_send    <= 1'b0;
    end else begin
      state      <= state_nxt;
      first_send <= (state == ST_LAUNCH);
      if (launch_new) begin
        current_dir   <= pend_dir;
        current_speed <= pend_speed;
      end
      if (state == ST_LAUNCH) begin
        tx_sel    <= current_dir;
        speed_out <= current_speed;
      end
      if (accept) begin
        pend_vld <= 1'b1;
      end else if (launch_new) begin
        pend_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pend_dir   <= sanitize_dir(dir_req);
      pend_speed <= speed_req;
    end
  end

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Directed bench for motor_cmd_scheduler with short gap/refresh/timeout counts.
module tb_motor_cmd_scheduler;

  logic       clk;
  logic       rst;
  logic [2:0] dir_req;
  logic [2:0] speed_req;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] gen_done;
  logic [4:0] gen_rst;
  logic [2:0] tx_sel;
  logic [2:0] speed_out;
  logic       busy;
  logic       timeout_err;

  int n_assert = 0;
  int n_fail   = 0;
  logic saw_busy;

  motor_cmd_scheduler #(
    .GAP_CLKS     (4),
    .REFRESH_CLKS (100),
    .TIMEOUT_CLKS (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dir_req     (dir_req),
    .speed_req   (speed_req),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .gen_done    (gen_done),
    .gen_rst     (gen_rst),
    .tx_sel      (tx_sel),
    .speed_out   (speed_out),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dir_req = 3'd0; speed_req = 3'd0; req_valid = 1'b0; gen_done = 5'd0;
    tick(3);
    chk("rst_gen_rst",     8'(gen_rst),     8'h1f);
    chk("rst_tx_sel",      8'(tx_sel),      8'd0);
    chk("rst_speed_out",   8'(speed_out),   8'd0);
    chk("rst_req_ready",   8'(req_ready),   8'd1);
    chk("rst_busy",        8'(busy),        8'd0);
    chk("rst_timeout_err", 8'(timeout_err), 8'd0);
    rst = 1'b0;
    tick(1);
    chk("idle_busy", 8'(busy), 8'd0);

    // BACKWARD speed 5, normal completion
    dir_req = 3'd2; speed_req = 3'd5; req_valid = 1'b1;
    tick(1);
    chk("t1_accept_ready", 8'(req_ready), 8'd0);
    chk("t1_still_idle",   8'(busy),      8'd0);
    req_valid = 1'b0;
    tick(1);
    chk("t1_launch_busy",    8'(busy),      8'd1);
    chk("t1_launch_gen_rst", 8'(gen_rst),   8'h1f);
    chk("t1_launch_ready",   8'(req_ready), 8'd1);
    tick(1);
    chk("t1_send_gen_rst", 8'(gen_rst),   8'b0001_1011);
    chk("t1_send_tx_sel",  8'(tx_sel),    8'd2);
    chk("t1_send_speed",   8'(speed_out), 8'd5);
    gen_done = 5'b00010;
    tick(1);
    chk("t1_ignore_unselected", 8'(gen_rst), 8'b0001_1011);
    gen_done = 5'b00100;
    tick(1);
    chk("t1_gap_gen_rst", 8'(gen_rst), 8'h1f);
    chk("t1_gap_busy",    8'(busy),    8'd1);
    chk("t1_gap_tx_sel",  8'(tx_sel),  8'd2);
    gen_done = 5'd0;
    tick(3);
    chk("t1_gap4_busy", 8'(busy), 8'd1);
    tick(1);
    chk("t1_idle_busy",  8'(busy),      8'd0);
    chk("t1_idle_speed", 8'(speed_out), 8'd5);

    // FORWARD speed 3, two SENDING cycles, then heartbeat relaunch
    dir_req = 3'd1; speed_req = 3'd3; req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
    tick(1);
    chk("t2_launch_busy", 8'(busy), 8'd1);
    tick(1);
    chk("t2_send_gen_rst", 8'(gen_rst), 8'b0001_1101);
    gen_done = 5'b00010;
    tick(1);
    chk("t2_first_cycle_ignored", 8'(gen_rst), 8'b0001_1101);
    tick(1);
    gen_done = 5'd0;
    chk("t2_gap_gen_rst", 8'(gen_rst), 8'h1f);
    tick(99);
    chk("t2_pre_heartbeat_idle", 8'(busy), 8'd0);
    tick(1);
    chk("t2_heartbeat_launch",   8'(busy),    8'd1);
    chk("t2_heartbeat_gen_rst",  8'(gen_rst), 8'h1f);
    tick(1);
    chk("t2_heartbeat_send",   8'(gen_rst),   8'b0001_1101);
    chk("t2_heartbeat_tx_sel", 8'(tx_sel),    8'd1);
    chk("t2_heartbeat_speed",  8'(speed_out), 8'd3);

    // Invalid direction 7 queued during the heartbeat, executed as STOP
    dir_req = 3'd7; speed_req = 3'd6; req_valid = 1'b1; gen_done = 5'b00010;
    tick(1);
    chk("t3_pending_ready", 8'(req_ready), 8'd0);
    req_valid = 1'b0;
    tick(1);
    gen_done = 5'd0;
    tick(4);
    tick(1);
    tick(1);
    chk("t3_stop_gen_rst", 8'(gen_rst),   8'b0001_1110);
    chk("t3_stop_tx_sel",  8'(tx_sel),    8'd0);
    chk("t3_stop_speed",   8'(speed_out), 8'd6);
    gen_done = 5'b00001;
    tick(2);
    gen_done = 5'd0;
    tick(4);
    chk("t3_stop_idle", 8'(busy), 8'd0);
    saw_busy = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      saw_busy = saw_busy | busy;
    end
    chk("t3_no_stop_refresh", 8'(saw_busy), 8'd0);

    // LEFT speed 1 with no done: timeout on SENDING cycle 50
    dir_req = 3'd3; speed_req = 3'd1; req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
    tick(2);
    chk("t4_send_gen_rst", 8'(gen_rst),     8'b0001_0111);
    chk("t4_c1_no_tmo",    8'(timeout_err), 8'd0);
    tick(48);
    chk("t4_c49_no_tmo",   8'(timeout_err), 8'd0);
    tick(1);
    chk("t4_c50_tmo",      8'(timeout_err), 8'd1);
    chk("t4_c50_gen_rst",  8'(gen_rst),     8'b0001_0111);
    tick(1);
    chk("t4_gap_tmo_low",  8'(timeout_err), 8'd0);
    chk("t4_gap_gen_rst",  8'(gen_rst),     8'h1f);
    chk("t4_gap_busy",     8'(busy),        8'd1);
    tick(4);
    chk("t4_idle_busy",    8'(busy),        8'd0);

    // BACKWARD in flight, LEFT then RIGHT requested during SENDING
    dir_req = 3'd2; speed_req = 3'd2; req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
    tick(2);
    dir_req = 3'd3; speed_req = 3'd4; req_valid = 1'b1;
    tick(1);
    chk("t5_left_accepted", 8'(req_ready), 8'd0);
    dir_req = 3'd4; speed_req = 3'd6;
    tick(1);
    chk("t5_right_stalls", 8'(req_ready), 8'd0);
    chk("t5_back_sending", 8'(gen_rst),   8'b0001_1011);
    gen_done = 5'b00100;
    tick(1);
    gen_done = 5'd0;
    chk("t5_gap_ready",  8'(req_ready), 8'd0);
    chk("t5_gap_tx_sel", 8'(tx_sel),    8'd2);
    tick(4);
    chk("t5_idle_ready", 8'(req_ready), 8'd0);
    chk("t5_idle_busy",  8'(busy),      8'd0);
    tick(1);
    chk("t5_left_launch_ready", 8'(req_ready), 8'd1);
    chk("t5_left_launch_tx",    8'(tx_sel),    8'd2);
    tick(1);
    chk("t5_right_accepted", 8'(req_ready), 8'd0);
    chk("t5_left_gen_rst",   8'(gen_rst),   8'b0001_0111);
    chk("t5_left_tx_sel",    8'(tx_sel),    8'd3);
    chk("t5_left_speed",     8'(speed_out), 8'd4);
    req_valid = 1'b0;
    gen_done = 5'b01000;
    tick(2);
    gen_done = 5'd0;
    tick(4);
    tick(2);
    chk("t5_right_gen_rst", 8'(gen_rst),   8'b0000_1111);
    chk("t5_right_tx_sel",  8'(tx_sel),    8'd4);
    chk("t5_right_speed",   8'(speed_out), 8'd6);
    chk("t5_right_ready",   8'(req_ready), 8'd1);

    // Reset mid-SENDING with a request pending
    dir_req = 3'd1; speed_req = 3'd7; req_valid = 1'b1;
    tick(1);
    chk("t6_pending_ready", 8'(req_ready), 8'd0);
    chk("t6_still_sending", 8'(gen_rst),   8'b0000_1111);
    req_valid = 1'b0; rst = 1'b1;
    tick(1);
    chk("t6_rst_gen_rst", 8'(gen_rst),   8'h1f);
    chk("t6_rst_tx_sel",  8'(tx_sel),    8'd0);
    chk("t6_rst_speed",   8'(speed_out), 8'd0);
    chk("t6_rst_ready",   8'(req_ready), 8'd1);
    chk("t6_rst_busy",    8'(busy),      8'd0);
    rst = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      saw_busy = saw_busy | busy;
    end
    chk("t6_no_launch_after_rst", 8'(saw_busy), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
